// File: rtl/countdown_timer.sv
// countdown_timer: settable BCD countdown timer with its own 1 ms timebase.
// Counts hh:mm:ss.mmm down to zero and flags expiry.
module countdown_timer #(
    parameter int CLK_PER_MS = 100000,
    parameter int MAX_HOURS  = 23
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        button,
    input  logic        start_stop,
    input  logic [5:0]  set,
    output logic [11:0] Milli_o,
    output logic [7:0]  Seconds_o,
    output logic [7:0]  Minutes_o,
    output logic [7:0]  Hours_o,
    output logic [1:0]  state_o,
    output logic [1:0]  field_o,
    output logic        expired
);
    localparam int PW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [5:0] MAX_H = 6'(MAX_HOURS);
    localparam logic [1:0] S_SET = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_EXP = 2'b11;
    localparam logic [1:0] F_SEC = 2'b00, F_MIN = 2'b01, F_HR = 2'b10;

    logic [1:0]    state_q, state_d, field_q, field_d;
    logic [11:0]   milli_q, milli_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          btn_prev_q, btn_prev_d, ss_prev_q, ss_prev_d;
    logic          btn_edge, ss_edge, tick, nonzero, is_one, borrow_s, borrow_m, borrow_h;
    logic [5:0]    clamp_sm, clamp_h;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Two-digit BCD decrement; wrap is the value that follows 00.
    function automatic logic [7:0] dec2(input logic [7:0] v, input logic [7:0] wrap);
        return v == 8'h00 ? wrap : v[3:0] == 4'h0 ? {v[7:4] - 4'h1, 4'h9} : {v[7:4], v[3:0] - 4'h1};
    endfunction

    function automatic logic [11:0] dec3(input logic [11:0] v);
        return v == 12'h000 ? 12'h999 : {v[7:0] == 8'h00 ? v[11:8] - 4'h1 : v[11:8], dec2(v[7:0], 8'h99)};
    endfunction

    assign btn_edge = button & ~btn_prev_q;
    assign ss_edge  = start_stop & ~ss_prev_q;
    assign tick     = pre_q == PRE_MAX;
    assign nonzero  = |{hr_q, min_q, sec_q, milli_q};
    assign is_one   = {hr_q, min_q, sec_q, milli_q} == 36'h1;
    assign borrow_s = milli_q == 12'h000;
    assign borrow_m = borrow_s && sec_q == 8'h00;
    assign borrow_h = borrow_m && min_q == 8'h00;
    assign clamp_sm = set > 6'd59 ? 6'd59 : set;
    assign clamp_h  = set > MAX_H ? MAX_H : set;

    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        milli_d    = milli_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        pre_d      = pre_q;
        btn_prev_d = button;
        ss_prev_d  = start_stop;
        if (ss_edge) begin
            if ((state_q == S_SET && nonzero) || state_q == S_PAUSE) begin
                state_d = S_RUN;
                pre_d   = '0;
            end else if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
        end else if (btn_edge) begin
            if (state_q == S_SET) begin
                milli_d = '0;
                if (field_q == F_SEC) sec_d = to_bcd(clamp_sm);
                else if (field_q == F_MIN) min_d = to_bcd(clamp_sm);
                else hr_d = to_bcd(clamp_h);
                field_d = field_q == F_HR ? F_SEC : field_q + 2'd1;
            end else if (state_q != S_RUN) begin
                state_d = S_SET;
                field_d = F_SEC;
                milli_d = '0;
                sec_d   = '0;
                min_d   = '0;
                hr_d    = '0;
            end
        end else if (state_q == S_RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick && is_one) begin
                milli_d = '0;
                state_d = S_EXP;
            end else if (tick) begin
                milli_d = dec3(milli_q);
                sec_d   = borrow_s ? dec2(sec_q, 8'h59) : sec_q;
                min_d   = borrow_m ? dec2(min_q, 8'h59) : min_q;
                hr_d    = borrow_h ? dec2(hr_q, 8'h00) : hr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_SET;
            field_q    <= F_SEC;
            milli_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            pre_q      <= '0;
            btn_prev_q <= 1'b1;
            ss_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            milli_q    <= milli_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            pre_q      <= pre_d;
            btn_prev_q <= btn_prev_d;
            ss_prev_q  <= ss_prev_d;
        end
    end

    assign Milli_o   = milli_q;
    assign Seconds_o = sec_q;
    assign Minutes_o = min_q;
    assign Hours_o   = hr_q;
    assign state_o   = state_q;
    assign field_o   = field_q;
    assign expired   = state_q == S_EXP;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus checked every cycle against
// a model that keeps the remaining time as a plain millisecond count.
module tb_countdown_timer;
    localparam int CPM  = 4;
    localparam int MAXH = 23;

    logic        clk = 0, resetn = 0, button = 1, start_stop = 0;
    logic [5:0]  set = 6'd5;
    logic [11:0] Milli_o;
    logic [7:0]  Seconds_o, Minutes_o, Hours_o;
    logic [1:0]  state_o, field_o;
    logic        expired;
    int          n_chk = 0, n_fail = 0;
    bit          chk_en = 0;

    countdown_timer #(.CLK_PER_MS(CPM), .MAX_HOURS(MAXH)) dut (
        .clk(clk), .resetn(resetn), .button(button), .start_stop(start_stop), .set(set),
        .Milli_o(Milli_o), .Seconds_o(Seconds_o), .Minutes_o(Minutes_o), .Hours_o(Hours_o),
        .state_o(state_o), .field_o(field_o), .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   ms;
        int   st;
        int   fld;
        int   pre;
        logic bp;
        logic sp;
    } m_t;

    m_t m;

    function automatic m_t m_reset();
        m_t r;
        r.ms = 0; r.st = 0; r.fld = 0; r.pre = 0; r.bp = 1; r.sp = 1;
        return r;
    endfunction

    // One clock of the timer rules, on total milliseconds remaining.
    function automatic m_t step(m_t c, logic b, logic s, logic [5:0] v);
        m_t n;
        int h, mi, sc, x;
        logic be, se;
        n = c;
        be = b && !c.bp;
        se = s && !c.sp;
        n.bp = b;
        n.sp = s;
        h = c.ms / 3600000;
        mi = (c.ms / 60000) % 60;
        sc = (c.ms / 1000) % 60;
        x = int'(v);
        if (se) begin
            if ((c.st == 0 && c.ms != 0) || c.st == 2) begin
                n.st = 1;
                n.pre = 0;
            end else if (c.st == 1) n.st = 2;
        end else if (be) begin
            if (c.st == 0) begin
                if (c.fld == 0) sc = x > 59 ? 59 : x;
                else if (c.fld == 1) mi = x > 59 ? 59 : x;
                else h = x > MAXH ? MAXH : x;
                n.ms = h * 3600000 + mi * 60000 + sc * 1000;
                n.fld = (c.fld + 1) % 3;
            end else if (c.st != 1) begin
                n.st = 0; n.ms = 0; n.fld = 0;
            end
        end else if (c.st == 1) begin
            if (c.pre == CPM - 1) begin
                n.pre = 0;
                n.ms = c.ms - 1;
                if (n.ms == 0) n.st = 3;
            end else n.pre = c.pre + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn)
        if (!resetn) m <= m_reset();
        else m <= step(m, button, start_stop, set);

    function automatic logic [7:0] bcd2(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] bcd3(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en) begin
            chk("model_milli", 32'(Milli_o), 32'(bcd3(m.ms % 1000)));
            chk("model_sec", 32'(Seconds_o), 32'(bcd2((m.ms / 1000) % 60)));
            chk("model_min", 32'(Minutes_o), 32'(bcd2((m.ms / 60000) % 60)));
            chk("model_hr", 32'(Hours_o), 32'(bcd2(m.ms / 3600000)));
            chk("model_state", 32'(state_o), 32'(m.st));
            chk("model_field", 32'(field_o), 32'(m.fld));
            chk("model_expired", 32'(expired), 32'(m.st == 3));
        end

    task automatic pulse_btn();
        @(negedge clk) button = 1;
        @(negedge clk) button = 0;
    endtask

    task automatic pulse_ss();
        @(negedge clk) start_stop = 1;
        @(negedge clk) start_stop = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetn = 0;
        @(negedge clk) resetn = 1;
    endtask

    task automatic load3(input logic [5:0] s, input logic [5:0] mi, input logic [5:0] h);
        set = s;  pulse_btn();
        set = mi; pulse_btn();
        set = h;  pulse_btn();
    endtask

    task automatic chk_time(input string nm, input logic [35:0] exp);
        chk({nm, "_hr"}, 32'(Hours_o), 32'(exp[35:28]));
        chk({nm, "_min"}, 32'(Minutes_o), 32'(exp[27:20]));
        chk({nm, "_sec"}, 32'(Seconds_o), 32'(exp[19:12]));
        chk({nm, "_milli"}, 32'(Milli_o), 32'(exp[11:0]));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk_time("reset", 36'h0);
        chk("reset_state", 32'(state_o), 0);
        resetn = 1;
        repeat (3) @(negedge clk);
        chk("held_btn_field", 32'(field_o), 0);
        chk_time("held_btn", 36'h0);
        button = 0;

        load3(6'd45, 6'd7, 6'd30);
        chk_time("load", 36'h23_07_45_000);
        chk("load_field", 32'(field_o), 0);

        do_reset();
        set = 6'd1;
        pulse_btn();
        pulse_ss();
        repeat (3) @(negedge clk);
        chk_time("pre_tick", 36'h00_00_01_000);
        @(negedge clk);
        chk_time("first_tick", 36'h00_00_00_999);
        n = 4;
        while (!expired && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("expire_latency", n, 4000);
        chk_time("expired", 36'h0);
        chk("expired_state", 32'(state_o), 3);
        pulse_ss();
        chk("exp_ignores_ss", 32'(state_o), 3);
        pulse_btn();
        chk("exp_btn_state", 32'(state_o), 0);

        load3(6'd0, 6'd0, 6'd1);
        pulse_ss();
        repeat (4) @(negedge clk);
        chk_time("borrow", 36'h00_59_59_999);
        pulse_ss();
        repeat (100) @(negedge clk);
        chk("pause_state", 32'(state_o), 2);
        chk_time("pause_hold", 36'h00_59_59_999);
        pulse_ss();
        repeat (3) @(negedge clk);
        chk_time("resume_pre", 36'h00_59_59_999);
        @(negedge clk);
        chk_time("resume_tick", 36'h00_59_59_998);
        pulse_ss();
        pulse_btn();
        chk("pause_btn_state", 32'(state_o), 0);
        chk("pause_btn_field", 32'(field_o), 0);
        chk_time("pause_btn", 36'h0);

        set = 6'd10;
        pulse_btn();
        @(negedge clk) begin set = 6'd20; button = 1; start_stop = 1; end
        @(negedge clk) begin button = 0; start_stop = 0; end
        chk("simul_state", 32'(state_o), 1);
        chk("simul_field", 32'(field_o), 1);
        chk_time("simul", 36'h00_00_10_000);
        repeat (6) @(negedge clk);
        #2 resetn = 0;
        #1 chk("async_rst_state", 32'(state_o), 0);
        chk_time("async_rst", 36'h0);
        @(negedge clk) resetn = 1;
        pulse_ss();
        chk("zero_ss_state", 32'(state_o), 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) button = ~button;
            if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
            set = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 499) == 0) begin
                #2 resetn = 0;
                @(negedge clk) resetn = 1;
            end
        end
        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
